bp_be_mem_fault_pipe: RTL and testbench

//  Parametrised memory-pipe control/exception pipeline for the BE calculator.

---
 rtl/bp_be_mem_fault_pipe_if.sv | 63 ++++++
 rtl/bp_be_mem_fault_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_bp_be_mem_fault_pipe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_mem_fault_pipe_if.sv
// Request/response bundle between issue, the memory fault pipe and the D$/D-TLB.
// The slave modport is the pipe itself; the master modport is the issue/TLB side.
interface bp_be_mem_fault_pipe_if #(
  parameter int vaddr_width_p = 39,
  parameter int stages_p      = 2
);
  localparam int cnt_width_lp = $clog2(stages_p + 1);

  logic                     v_i;
  logic                     ready_o;
  logic [1:0]               size_i;
  logic                     is_store_i;
  logic                     is_fencei_i;
  logic [63:0]              rs1_i;
  logic [63:0]              imm_i;
  logic                     offset_sel_i;
  logic [vaddr_width_p-1:0] vaddr_ex0_o;
  logic                     stall_i;
  logic                     kill_i;
  logic                     flush_i;
  logic                     tlb_v_i;
  logic                     tlb_miss_i;
  logic                     tlb_u_i;
  logic                     tlb_w_i;
  logic                     tlb_d_i;
  logic                     translation_en_i;
  logic                     mstatus_sum_i;
  logic [1:0]               priv_mode_i;
  logic                     access_fault_i;
  logic                     v_o;
  logic [vaddr_width_p-1:0] vaddr_o;
  logic                     fencei_v_o;
  logic                     tlb_miss_v_o;
  logic                     ld_misaligned_v_o;
  logic                     st_misaligned_v_o;
  logic                     ld_page_fault_v_o;
  logic                     st_page_fault_v_o;
  logic                     ld_access_fault_v_o;
  logic                     st_access_fault_v_o;
  logic [cnt_width_lp-1:0]  inflight_o;

  modport slave (
    input  v_i, size_i, is_store_i, is_fencei_i, rs1_i, imm_i, offset_sel_i,
    input  stall_i, kill_i, flush_i,
    input  tlb_v_i, tlb_miss_i, tlb_u_i, tlb_w_i, tlb_d_i,
    input  translation_en_i, mstatus_sum_i, priv_mode_i, access_fault_i,
    output ready_o, vaddr_ex0_o, v_o, vaddr_o,
    output fencei_v_o, tlb_miss_v_o, ld_misaligned_v_o, st_misaligned_v_o,
    output ld_page_fault_v_o, st_page_fault_v_o, ld_access_fault_v_o, st_access_fault_v_o,
    output inflight_o
  );

  modport master (
    output v_i, size_i, is_store_i, is_fencei_i, rs1_i, imm_i, offset_sel_i,
    output stall_i, kill_i, flush_i,
    output tlb_v_i, tlb_miss_i, tlb_u_i, tlb_w_i, tlb_d_i,
    output translation_en_i, mstatus_sum_i, priv_mode_i, access_fault_i,
    input  ready_o, vaddr_ex0_o, v_o, vaddr_o,
    input  fencei_v_o, tlb_miss_v_o, ld_misaligned_v_o, st_misaligned_v_o,
    input  ld_page_fault_v_o, st_page_fault_v_o, ld_access_fault_v_o, st_access_fault_v_o,
    input  inflight_o
  );
endinterface

// File: rtl/bp_be_mem_fault_pipe.sv
// Memory-pipe control/exception pipeline: vaddr generation, stages_p-deep request pipe, one-shot
// D-TLB capture in stage 1, prioritised fault report. Misaligned checks need BP_BE_MISALIGN_CHECK_EN.
module bp_be_mem_fault_pipe #(
  parameter int vaddr_width_p = 39,
  parameter int stages_p      = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_be_mem_fault_pipe_if.slave bus
);

  localparam int         cnt_width_lp = $clog2(stages_p + 1);
  localparam logic [1:0] priv_u_lp    = 2'd0;
  localparam logic [1:0] priv_s_lp    = 2'd1;

  function automatic logic [cnt_width_lp-1:0] popcount(input logic [stages_p:1] vec);
    logic [cnt_width_lp-1:0] cnt;
    cnt = {cnt_width_lp{1'b0}};
    for (int k = 1; k <= stages_p; k++) begin
      cnt = cnt + {{(cnt_width_lp-1){1'b0}}, vec[k]};
    end
    return cnt;
  endfunction

  logic [63:0]              offset_s;
  logic [63:0]              sum_s;
  logic [vaddr_width_p-1:0] vaddr_ex0_s;
  logic                     accept_s;

  logic [stages_p:1]        v_q, v_d;
  logic [stages_p:1]        store_q, store_d;
  logic [stages_p:1]        fencei_q, fencei_d;
  logic [vaddr_width_p-1:0] vaddr_q [1:stages_p];
  logic [vaddr_width_p-1:0] vaddr_d [1:stages_p];
  logic [stages_p:2]        exc_miss_q, exc_miss_d;
  logic [stages_p:2]        exc_page_q, exc_page_d;
  logic [stages_p:2]        exc_acc_q, exc_acc_d;

  logic                     s1_smp_q, s1_smp_d;
  logic                     s1_miss_q, s1_miss_d;
  logic                     s1_page_q, s1_page_d;
  logic                     s1_acc_q, s1_acc_d;
  logic                     s1_miss_s, s1_page_s, s1_acc_s;
  logic                     priv_fault_s, live_page_s;
  logic                     pri_miss_s, pri_page_s, pri_acc_s;
  logic [cnt_width_lp-1:0]  inflight_q, inflight_d;
`ifdef BP_BE_MISALIGN_CHECK_EN
  logic                     mis_ex0_s;
  logic                     s1_mis_q, s1_mis_d;
  logic                     pri_mis_s;
  logic [stages_p:2]        exc_mis_q, exc_mis_d;
`endif

  assign offset_s        = bus.offset_sel_i ? 64'd0 : bus.imm_i;
  assign sum_s           = bus.rs1_i + offset_s;
  assign vaddr_ex0_s     = sum_s[vaddr_width_p-1:0];
  assign bus.vaddr_ex0_o = reset_n_i ? vaddr_ex0_s : {vaddr_width_p{1'b0}};
  assign bus.ready_o     = reset_n_i & ~bus.stall_i;
  assign accept_s        = bus.v_i & bus.ready_o & ~bus.flush_i;

`ifdef BP_BE_MISALIGN_CHECK_EN
  // Alignment check on the stage-0 address for the requested access size
  always_comb begin
    case (bus.size_i)
      2'd0:    mis_ex0_s = 1'b0;
      2'd1:    mis_ex0_s = vaddr_ex0_s[0];
      2'd2:    mis_ex0_s = |vaddr_ex0_s[1:0];
      2'd3:    mis_ex0_s = |vaddr_ex0_s[2:0];
      default: mis_ex0_s = 1'b0;
    endcase
  end
`endif

  // Live D-TLB permission evaluation for the entry currently in stage 1
  always_comb begin
    priv_fault_s = ((bus.priv_mode_i == priv_s_lp) & ~bus.mstatus_sum_i & bus.tlb_u_i)
                 | ((bus.priv_mode_i == priv_u_lp) & ~bus.tlb_u_i);
    if (bus.translation_en_i & bus.tlb_v_i) begin
      live_page_s = priv_fault_s | (store_q[1] & (~bus.tlb_w_i | ~bus.tlb_d_i));
    end else begin
      live_page_s = 1'b0;
    end
  end

  // Once captured, stage 1 keeps its first-cycle TLB view for the rest of a stall
  assign s1_miss_s = s1_smp_q ? s1_miss_q : bus.tlb_miss_i;
  assign s1_page_s = s1_smp_q ? s1_page_q : live_page_s;
  assign s1_acc_s  = s1_smp_q ? s1_acc_q  : bus.access_fault_i;

  // Reduce stage-1 fault causes to a single prioritised exception
  always_comb begin
    pri_miss_s = 1'b0;
    pri_page_s = 1'b0;
    pri_acc_s  = 1'b0;
`ifdef BP_BE_MISALIGN_CHECK_EN
    pri_mis_s  = 1'b0;
`endif
    if (fencei_q[1]) begin
      pri_miss_s = 1'b0;
`ifdef BP_BE_MISALIGN_CHECK_EN
    end else if (s1_mis_q) begin
      pri_mis_s = 1'b1;
`endif
    end else if (s1_miss_s) begin
      pri_miss_s = 1'b1;
    end else if (s1_page_s) begin
      pri_page_s = 1'b1;
    end else if (s1_acc_s) begin
      pri_acc_s = 1'b1;
    end else begin
      pri_acc_s = 1'b0;
    end
  end

  // Pipeline next state: flush, then stall/kill hold, otherwise advance
  always_comb begin
    v_d        = v_q;
    store_d    = store_q;
    fencei_d   = fencei_q;
    vaddr_d    = vaddr_q;
    exc_miss_d = exc_miss_q;
    exc_page_d = exc_page_q;
    exc_acc_d  = exc_acc_q;
    s1_smp_d   = s1_smp_q;
    s1_miss_d  = s1_miss_q;
    s1_page_d  = s1_page_q;
    s1_acc_d   = s1_acc_q;
`ifdef BP_BE_MISALIGN_CHECK_EN
    s1_mis_d   = s1_mis_q;
    exc_mis_d  = exc_mis_q;
`endif
    if (bus.flush_i) begin
      v_d      = {stages_p{1'b0}};
      s1_smp_d = 1'b0;
    end else if (bus.stall_i) begin
      v_d[1] = v_q[1] & ~bus.kill_i;
      if (v_q[1]) begin
        s1_smp_d  = 1'b1;
        s1_miss_d = s1_miss_s;
        s1_page_d = s1_page_s;
        s1_acc_d  = s1_acc_s;
      end else begin
        s1_smp_d  = s1_smp_q;
      end
    end else begin
      v_d[1]        = accept_s;
      store_d[1]    = bus.is_store_i;
      fencei_d[1]   = bus.is_fencei_i;
      vaddr_d[1]    = vaddr_ex0_s;
      s1_smp_d      = 1'b0;
      v_d[2]        = v_q[1] & ~bus.kill_i;
      store_d[2]    = store_q[1];
      fencei_d[2]   = fencei_q[1];
      vaddr_d[2]    = vaddr_q[1];
      exc_miss_d[2] = pri_miss_s;
      exc_page_d[2] = pri_page_s;
      exc_acc_d[2]  = pri_acc_s;
`ifdef BP_BE_MISALIGN_CHECK_EN
      s1_mis_d      = mis_ex0_s & ~bus.is_fencei_i;
      exc_mis_d[2]  = pri_mis_s;
`endif
      for (int k = 3; k <= stages_p; k++) begin
        v_d[k]        = v_q[k-1];
        store_d[k]    = store_q[k-1];
        fencei_d[k]   = fencei_q[k-1];
        vaddr_d[k]    = vaddr_q[k-1];
        exc_miss_d[k] = exc_miss_q[k-1];
        exc_page_d[k] = exc_page_q[k-1];
        exc_acc_d[k]  = exc_acc_q[k-1];
`ifdef BP_BE_MISALIGN_CHECK_EN
        exc_mis_d[k]  = exc_mis_q[k-1];
`endif
      end
    end
    inflight_d = popcount(v_d);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q        <= {stages_p{1'b0}};
      store_q    <= {stages_p{1'b0}};
      fencei_q   <= {stages_p{1'b0}};
      for (int k = 1; k <= stages_p; k++) begin
        vaddr_q[k] <= {vaddr_width_p{1'b0}};
      end
      exc_miss_q <= {(stages_p-1){1'b0}};
      exc_page_q <= {(stages_p-1){1'b0}};
      exc_acc_q  <= {(stages_p-1){1'b0}};
      s1_smp_q   <= 1'b0;
      s1_miss_q  <= 1'b0;
      s1_page_q  <= 1'b0;
      s1_acc_q   <= 1'b0;
      inflight_q <= {cnt_width_lp{1'b0}};
`ifdef BP_BE_MISALIGN_CHECK_EN
      s1_mis_q   <= 1'b0;
      exc_mis_q  <= {(stages_p-1){1'b0}};
`endif
    end else begin
      v_q        <= v_d;
      store_q    <= store_d;
      fencei_q   <= fencei_d;
      vaddr_q    <= vaddr_d;
      exc_miss_q <= exc_miss_d;
      exc_page_q <= exc_page_d;
      exc_acc_q  <= exc_acc_d;
      s1_smp_q   <= s1_smp_d;
      s1_miss_q  <= s1_miss_d;
      s1_page_q  <= s1_page_d;
      s1_acc_q   <= s1_acc_d;
      inflight_q <= inflight_d;
`ifdef BP_BE_MISALIGN_CHECK_EN
      s1_mis_q   <= s1_mis_d;
      exc_mis_q  <= exc_mis_d;
`endif
    end
  end

  assign bus.v_o                 = v_q[stages_p];
  assign bus.vaddr_o             = vaddr_q[stages_p];
  assign bus.inflight_o          = inflight_q;
  assign bus.fencei_v_o          = v_q[stages_p] & fencei_q[stages_p];
  assign bus.tlb_miss_v_o        = v_q[stages_p] & exc_miss_q[stages_p];
  assign bus.ld_page_fault_v_o   = v_q[stages_p] & exc_page_q[stages_p] & ~store_q[stages_p];
  assign bus.st_page_fault_v_o   = v_q[stages_p] & exc_page_q[stages_p] &  store_q[stages_p];
  assign bus.ld_access_fault_v_o = v_q[stages_p] & exc_acc_q[stages_p]  & ~store_q[stages_p];
  assign bus.st_access_fault_v_o = v_q[stages_p] & exc_acc_q[stages_p]  &  store_q[stages_p];
`ifdef BP_BE_MISALIGN_CHECK_EN
  assign bus.ld_misaligned_v_o   = v_q[stages_p] & exc_mis_q[stages_p] & ~store_q[stages_p];
  assign bus.st_misaligned_v_o   = v_q[stages_p] & exc_mis_q[stages_p] &  store_q[stages_p];
`else
  assign bus.ld_misaligned_v_o   = 1'b0;
  assign bus.st_misaligned_v_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_mem_fault_pipe.sv
// Directed bench for bp_be_mem_fault_pipe (stages_p=2), checked with immediate assertions.
module tb_bp_be_mem_fault_pipe;

  localparam int VA = 39;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] fl;

  bp_be_mem_fault_pipe_if #(.vaddr_width_p(VA), .stages_p(2)) bus ();

  bp_be_mem_fault_pipe #(.vaddr_width_p(VA), .stages_p(2)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // {fencei, tlb_miss, ld_mis, st_mis, ld_pf, st_pf, ld_af, st_af}
  assign fl = {bus.fencei_v_o, bus.tlb_miss_v_o, bus.ld_misaligned_v_o, bus.st_misaligned_v_o,
               bus.ld_page_fault_v_o, bus.st_page_fault_v_o, bus.ld_access_fault_v_o,
               bus.st_access_fault_v_o};

`ifdef BP_BE_MISALIGN_CHECK_EN
  localparam logic [7:0] EXP_ST_MIS = 8'h10;
  localparam logic [7:0] EXP_LD_MIS = 8'h20;
`else
  localparam logic [7:0] EXP_ST_MIS = 8'h40;
  localparam logic [7:0] EXP_LD_MIS = 8'h00;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.v_i = 1'b0; bus.size_i = 2'd0; bus.is_store_i = 1'b0; bus.is_fencei_i = 1'b0;
    bus.rs1_i = 64'd0; bus.imm_i = 64'd0; bus.offset_sel_i = 1'b0;
    bus.stall_i = 1'b0; bus.kill_i = 1'b0; bus.flush_i = 1'b0;
    bus.tlb_v_i = 1'b1; bus.tlb_miss_i = 1'b0; bus.tlb_u_i = 1'b0; bus.tlb_w_i = 1'b1;
    bus.tlb_d_i = 1'b1; bus.translation_en_i = 1'b0; bus.mstatus_sum_i = 1'b0;
    bus.priv_mode_i = 2'd3; bus.access_fault_i = 1'b0;
  endtask

  // One request: stage-0 fields, then stage-1 TLB view, then check the final stage
  task automatic do_req(input string tag, input logic [63:0] rs1, input logic [63:0] imm,
                        input logic osel, input logic [1:0] sz, input logic st, input logic fi,
                        input logic ten, input logic [1:0] pm, input logic sum, input logic tv,
                        input logic miss, input logic u, input logic w, input logic d,
                        input logic af, input logic [63:0] exp_va, input logic [7:0] exp_fl);
    bus.v_i = 1'b1; bus.rs1_i = rs1; bus.imm_i = imm; bus.offset_sel_i = osel;
    bus.size_i = sz; bus.is_store_i = st; bus.is_fencei_i = fi;
    #1;
    chk({tag, "_ex0"}, bus.vaddr_ex0_o, exp_va);
    step();
    bus.v_i = 1'b0;
    bus.translation_en_i = ten; bus.priv_mode_i = pm; bus.mstatus_sum_i = sum;
    bus.tlb_v_i = tv; bus.tlb_miss_i = miss; bus.tlb_u_i = u; bus.tlb_w_i = w;
    bus.tlb_d_i = d; bus.access_fault_i = af;
    chk({tag, "_early"}, bus.v_o, 64'd0);
    step();
    chk({tag, "_v"}, bus.v_o, 64'd1);
    chk({tag, "_va"}, bus.vaddr_o, exp_va);
    chk({tag, "_fl"}, fl, exp_fl);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    chk("rst_v", bus.v_o, 64'd0);
    chk("rst_va", bus.vaddr_o, 64'd0);
    chk("rst_infl", bus.inflight_o, 64'd0);
    chk("rst_rdy", bus.ready_o, 64'd0);
    chk("rst_fl", fl, 64'd0);
    #10 rst_n = 1'b1;
    step();
    chk("rdy", bus.ready_o, 64'd1);

    //       tag      rs1                     imm     os sz st fi ten pm    sum tv miss u w d af  exp_va      exp_fl
    do_req("load",   64'h1000,               64'd8,  0, 3, 0, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 0, 64'h1008,   8'h00);
    do_req("st_mis", 64'h1000,               64'd2,  0, 2, 1, 0, 0, 2'd3, 0, 1, 1,   0, 1, 1, 0, 64'h1002,   EXP_ST_MIS);
    do_req("ld_mis", 64'h1000,               64'd1,  0, 1, 0, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 0, 64'h1001,   EXP_LD_MIS);
    do_req("pf_u",   64'h2000,               64'd0,  0, 3, 0, 0, 1, 2'd0, 0, 1, 0,   0, 1, 1, 0, 64'h2000,   8'h08);
    do_req("pf_s",   64'h2008,               64'd0,  0, 3, 1, 0, 1, 2'd1, 0, 1, 0,   1, 1, 0, 0, 64'h2008,   8'h04);
    do_req("pf_d",   64'h2010,               64'd0,  0, 3, 1, 0, 1, 2'd1, 1, 1, 0,   1, 1, 0, 0, 64'h2010,   8'h04);
    do_req("sum_ok", 64'h2018,               64'd0,  0, 3, 0, 0, 1, 2'd1, 1, 1, 0,   1, 1, 0, 0, 64'h2018,   8'h00);
    do_req("no_ten", 64'h2020,               64'd0,  0, 3, 0, 0, 0, 2'd0, 0, 1, 0,   0, 1, 1, 0, 64'h2020,   8'h00);
    do_req("no_tv",  64'h2028,               64'd0,  0, 3, 0, 0, 1, 2'd0, 0, 0, 0,   0, 1, 1, 0, 64'h2028,   8'h00);
    do_req("ld_af",  64'h2030,               64'd0,  0, 3, 0, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 1, 64'h2030,   8'h02);
    do_req("st_af",  64'h2038,               64'd0,  0, 3, 1, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 1, 64'h2038,   8'h01);
    do_req("pf>af",  64'h2040,               64'd0,  0, 3, 0, 0, 1, 2'd0, 0, 1, 0,   0, 1, 1, 1, 64'h2040,   8'h08);
    do_req("mis>pf", 64'h2048,               64'd0,  0, 3, 0, 0, 1, 2'd0, 0, 1, 1,   0, 1, 1, 1, 64'h2048,   8'h40);
    do_req("fencei", 64'h1001,               64'd0,  0, 3, 0, 1, 1, 2'd0, 0, 1, 1,   0, 1, 1, 1, 64'h1001,   8'h80);
    do_req("osel",   64'h3000,               64'h10, 1, 3, 0, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 0, 64'h3000,   8'h00);
    do_req("wrap",   64'hFFFF_FFFF_FFFF_FFF8, 64'd16, 0, 3, 0, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 0, 64'h8,      8'h00);
    do_req("trunc",  64'h0000_0080_0000_0010, 64'd0,  0, 3, 0, 0, 0, 2'd3, 0, 1, 0,   0, 1, 1, 0, 64'h10,     8'h00);

    // Back-to-back A, B, C, then a 3-cycle stall; C samples its TLB view in the first stalled cycle
    bus.v_i = 1'b1; bus.rs1_i = 64'h100; step();
    bus.rs1_i = 64'h200; step();
    bus.rs1_i = 64'h300;
    chk("b2b_a", bus.vaddr_o, 64'h100);
    step();
    bus.v_i = 1'b0; bus.stall_i = 1'b1; bus.access_fault_i = 1'b1;
    #1;
    chk("stall_rdy", bus.ready_o, 64'd0);
    chk("stall_v", bus.v_o, 64'd1);
    chk("stall_va0", bus.vaddr_o, 64'h200);
    chk("stall_infl0", bus.inflight_o, 64'd2);
    chk("stall_fl", fl, 64'd0);
    step();
    bus.access_fault_i = 1'b0; bus.tlb_miss_i = 1'b1; bus.v_i = 1'b1; bus.rs1_i = 64'h999;
    chk("stall_va1", bus.vaddr_o, 64'h200);
    chk("stall_infl1", bus.inflight_o, 64'd2);
    step();
    chk("stall_va2", bus.vaddr_o, 64'h200);
    chk("stall_infl2", bus.inflight_o, 64'd2);
    step();
    bus.stall_i = 1'b0; bus.v_i = 1'b0; bus.tlb_miss_i = 1'b0;
    chk("stall_va3", bus.vaddr_o, 64'h200);
    step();
    chk("c_v", bus.v_o, 64'd1);
    chk("c_va", bus.vaddr_o, 64'h300);
    chk("c_fl", fl, 64'h02);
    chk("c_infl", bus.inflight_o, 64'd1);
    step();
    chk("drain_v", bus.v_o, 64'd0);
    chk("drain_infl", bus.inflight_o, 64'd0);

    // Kill A in its stage-1 cycle; B follows untouched
    bus.v_i = 1'b1; bus.rs1_i = 64'h400; step();
    bus.rs1_i = 64'h500; bus.kill_i = 1'b1; step();
    bus.v_i = 1'b0; bus.kill_i = 1'b0;
    chk("kill_v", bus.v_o, 64'd0);
    chk("kill_infl", bus.inflight_o, 64'd1);
    step();
    chk("kill_b_v", bus.v_o, 64'd1);
    chk("kill_b_va", bus.vaddr_o, 64'h500);
    step();
    chk("kill_end", bus.v_o, 64'd0);

    // Kill while stalled
    bus.v_i = 1'b1; bus.rs1_i = 64'h600; step();
    bus.v_i = 1'b0; bus.stall_i = 1'b1; bus.kill_i = 1'b1; step();
    bus.stall_i = 1'b0; bus.kill_i = 1'b0;
    chk("kill_stall_infl", bus.inflight_o, 64'd0);
    step();
    chk("kill_stall_v", bus.v_o, 64'd0);

    // Flush with a simultaneous request
    bus.v_i = 1'b1; bus.rs1_i = 64'h700; step();
    bus.rs1_i = 64'h800; step();
    bus.rs1_i = 64'h900; bus.flush_i = 1'b1;
    chk("pre_flush_va", bus.vaddr_o, 64'h700);
    step();
    bus.v_i = 1'b0; bus.flush_i = 1'b0;
    chk("flush_infl", bus.inflight_o, 64'd0);
    chk("flush_v0", bus.v_o, 64'd0);
    step();
    chk("flush_v1", bus.v_o, 64'd0);
    chk("flush_infl1", bus.inflight_o, 64'd0);

    // Flush beats stall
    bus.v_i = 1'b1; bus.rs1_i = 64'hA00; step();
    bus.v_i = 1'b0; bus.stall_i = 1'b1; bus.flush_i = 1'b1; step();
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    chk("flush_stall_infl", bus.inflight_o, 64'd0);

    // Asynchronous reset mid-stream, then normal operation
    bus.v_i = 1'b1; bus.rs1_i = 64'h5000; bus.size_i = 2'd3; step();
    bus.v_i = 1'b0; bus.translation_en_i = 1'b1; bus.priv_mode_i = 2'd0; bus.tlb_u_i = 1'b0;
    step();
    chk("pre_rst_fl", fl, 64'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", bus.v_o, 64'd0);
    chk("arst_va", bus.vaddr_o, 64'd0);
    chk("arst_fl", fl, 64'd0);
    chk("arst_infl", bus.inflight_o, 64'd0);
    chk("arst_rdy", bus.ready_o, 64'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    do_req("post_rst", 64'h6000, 64'd8, 0, 3, 0, 0, 0, 2'd3, 0, 1, 0, 0, 1, 1, 0, 64'h6008, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
